// File: rtl/pong_match_fsm.sv
// Pong match controller: game FSM, score counters, serve countdown, winner and serve direction.
// Optional pause mode is built only when PONG_PAUSE_EN is defined.
module pong_match_fsm #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int WIN_MARGIN  = 1,
  parameter int SERVE_TICKS = 60,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start,
  input  logic               restart,
  input  logic               pause_btn,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic [1:0]         winner,
  output logic               serve_dir,
  output logic               ball_en,
  output logic [CNT_W-1:0]   countdown
);

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  state_t             r_state, w_state_nx;
  logic [SCORE_W-1:0] r_p1, r_p2, w_p1_nx, w_p2_nx;
  logic [1:0]         r_winner, w_winner_nx;
  logic               r_serve_dir, w_serve_dir_nx;
  logic               r_ball_en;
  logic [CNT_W-1:0]   r_countdown, w_cd_nx;
  logic               r_start_q, r_restart_q;
  logic               w_start_edge, w_restart_edge;
  logic [SCORE_W-1:0] w_p1_inc, w_p2_inc;
  logic               w_p1_win, w_p2_win;

`ifdef PONG_PAUSE_EN
  logic   r_pause_q, w_pause_edge;
  state_t r_saved, w_saved_nx;
  assign w_pause_edge = pause_btn & ~r_pause_q;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause_btn;
`endif

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s, input logic inc);
    if (inc && (s != {SCORE_W{1'b1}}))
      return s + SCORE_W'(1);
    return s;
  endfunction

  function automatic logic wins(input logic [SCORE_W-1:0] me, input logic [SCORE_W-1:0] opp);
    return (32'(me) >= 32'(WIN_SCORE)) && (32'(me) >= 32'(opp) + 32'(WIN_MARGIN));
  endfunction

  assign w_start_edge   = start & ~r_start_q;
  assign w_restart_edge = restart & ~r_restart_q;
  assign w_p1_inc       = sat_inc(r_p1, point_p1);
  assign w_p2_inc       = sat_inc(r_p2, point_p2);
  assign w_p1_win       = wins(w_p1_inc, w_p2_inc);
  assign w_p2_win       = wins(w_p2_inc, w_p1_inc);

  always_comb begin
    w_state_nx     = r_state;
    w_p1_nx        = r_p1;
    w_p2_nx        = r_p2;
    w_winner_nx    = r_winner;
    w_serve_dir_nx = r_serve_dir;
    w_cd_nx        = r_countdown;
`ifdef PONG_PAUSE_EN
    w_saved_nx     = r_saved;
`endif
    case (r_state)
      ST_MENU: begin
        if (w_start_edge) begin
          w_p1_nx        = '0;
          w_p2_nx        = '0;
          w_winner_nx    = 2'd0;
          w_serve_dir_nx = 1'b1;
          w_cd_nx        = CNT_W'(SERVE_TICKS);
          w_state_nx     = ST_SERVE;
        end
      end
      ST_SERVE: begin
`ifdef PONG_PAUSE_EN
        if (w_pause_edge) begin
          w_saved_nx = ST_SERVE;
          w_state_nx = ST_PAUSE;
        end else
`endif
        if (timing_tick) begin
          // A stray zero count still launches rather than wrapping round
          if (r_countdown <= CNT_W'(1)) begin
            w_cd_nx    = '0;
            w_state_nx = ST_PLAY;
          end else begin
            w_cd_nx = r_countdown - CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (point_p1 || point_p2) begin
          w_p1_nx = w_p1_inc;
          w_p2_nx = w_p2_inc;
          if (w_p1_win) begin
            w_winner_nx = 2'd1;
            w_state_nx  = ST_OVER;
          end else if (w_p2_win) begin
            w_winner_nx = 2'd2;
            w_state_nx  = ST_OVER;
          end else begin
            w_cd_nx    = CNT_W'(SERVE_TICKS);
            w_state_nx = ST_SERVE;
            // Serve toward whoever conceded; a shared point keeps the direction
            if (point_p1 && !point_p2)
              w_serve_dir_nx = 1'b1;
            else if (point_p2 && !point_p1)
              w_serve_dir_nx = 1'b0;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (w_pause_edge) begin
          w_saved_nx = ST_PLAY;
          w_state_nx = ST_PAUSE;
        end
`endif
      end
      ST_OVER: begin
        if (w_restart_edge)
          w_state_nx = ST_MENU;
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSE: begin
        if (w_pause_edge)
          w_state_nx = r_saved;
        else if (w_restart_edge)
          w_state_nx = ST_MENU;
      end
`endif
      default: w_state_nx = ST_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_MENU;
      r_p1        <= '0;
      r_p2        <= '0;
      r_winner    <= 2'd0;
      r_serve_dir <= 1'b1;
      r_ball_en   <= 1'b0;
      r_countdown <= '0;
      r_start_q   <= 1'b0;
      r_restart_q <= 1'b0;
`ifdef PONG_PAUSE_EN
      r_pause_q   <= 1'b0;
      r_saved     <= ST_MENU;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_p1        <= w_p1_nx;
      r_p2        <= w_p2_nx;
      r_winner    <= w_winner_nx;
      r_serve_dir <= w_serve_dir_nx;
      r_ball_en   <= (w_state_nx == ST_PLAY);
      r_countdown <= w_cd_nx;
      r_start_q   <= start;
      r_restart_q <= restart;
`ifdef PONG_PAUSE_EN
      r_pause_q   <= pause_btn;
      r_saved     <= w_saved_nx;
`endif
    end
  end

  assign state         = r_state;
  assign player1_score = r_p1;
  assign player2_score = r_p2;
  assign winner        = r_winner;
  assign serve_dir     = r_serve_dir;
  assign ball_en       = r_ball_en;
  assign countdown     = r_countdown;

endmodule

// File: tb/tb_pong_match_fsm.sv
// Directed bench for pong_match_fsm (WIN_MARGIN=2): serve, scoring, win rules, buttons, pause, reset.
module tb_pong_match_fsm;

  logic       clk = 1'b0;
  logic       rst, timing_tick, start, restart, pause_btn, point_p1, point_p2;
  logic [2:0] state;
  logic [3:0] player1_score, player2_score;
  logic [1:0] winner;
  logic       serve_dir, ball_en;
  logic [7:0] countdown;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PONG_PAUSE_EN
  localparam int EXP_PAUSE_ST = 4;
  localparam int EXP_CD_AFTER = 30;
`else
  localparam int EXP_PAUSE_ST = 1;
  localparam int EXP_CD_AFTER = 20;
`endif

  always #5 clk = ~clk;

  pong_match_fsm #(
    .SCORE_W(4), .WIN_SCORE(9), .WIN_MARGIN(2), .SERVE_TICKS(60), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .start(start),
    .restart(restart), .pause_btn(pause_btn), .point_p1(point_p1),
    .point_p2(point_p2), .state(state), .player1_score(player1_score),
    .player2_score(player2_score), .winner(winner), .serve_dir(serve_dir),
    .ball_en(ball_en), .countdown(countdown)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pt(input logic a, input logic b);
    point_p1 = a;
    point_p2 = b;
    step();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
  endtask

  task automatic serve_until_play();
    timing_tick = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (state == 3'd2) break;
      step();
    end
    timing_tick = 1'b0;
    chk("serve_to_play", 32'(state), 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int       trans;
    logic [2:0] prev;
    rst = 1'b1; timing_tick = 1'b0; start = 1'b0; restart = 1'b0;
    pause_btn = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_p1", 32'(player1_score), 0);
    chk("rst_p2", 32'(player2_score), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_serve_dir", 32'(serve_dir), 1);
    chk("rst_ball_en", 32'(ball_en), 0);
    chk("rst_countdown", 32'(countdown), 0);
    rst = 1'b0;
    step();

    // Held start yields a single transition
    start = 1'b1;
    trans = 0;
    prev  = state;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state != prev) trans++;
      prev = state;
    end
    start = 1'b0;
    chk("start_hold_trans", 32'(trans), 1);
    chk("start_state", 32'(state), 1);
    chk("start_countdown", 32'(countdown), 60);
    chk("serve_ball_en", 32'(ball_en), 0);

    timing_tick = 1'b1;
    for (int i = 0; i < 59; i++) step();
    chk("tick59_state", 32'(state), 1);
    chk("tick59_countdown", 32'(countdown), 1);
    chk("tick59_ball_en", 32'(ball_en), 0);
    step();
    timing_tick = 1'b0;
    chk("tick60_state", 32'(state), 2);
    chk("tick60_countdown", 32'(countdown), 0);
    chk("tick60_ball_en", 32'(ball_en), 1);

    pt(1'b0, 1'b1);
    chk("p2pt_state", 32'(state), 1);
    chk("p2pt_score", 32'(player2_score), 1);
    chk("p2pt_p1", 32'(player1_score), 0);
    chk("p2pt_serve_dir", 32'(serve_dir), 0);
    chk("p2pt_countdown", 32'(countdown), 60);
    chk("p2pt_ball_en", 32'(ball_en), 0);

    // Pause at countdown 30
    timing_tick = 1'b1;
    for (int i = 0; i < 30; i++) step();
    timing_tick = 1'b0;
    chk("prepause_cd", 32'(countdown), 30);
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    chk("pause_state", 32'(state), 32'(EXP_PAUSE_ST));
    chk("pause_ball_en", 32'(ball_en), 0);
    timing_tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      point_p1 = (i == 4);
      step();
    end
    point_p1 = 1'b0;
    timing_tick = 1'b0;
    chk("pause_cd_frozen", 32'(countdown), 32'(EXP_CD_AFTER));
    chk("pause_point_ign", 32'(player1_score), 0);
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    chk("unpause_state", 32'(state), 1);
    chk("unpause_cd", 32'(countdown), 32'(EXP_CD_AFTER));
    serve_until_play();

    // Game 1: player 1 wins 9:3
    pt(1'b0, 1'b1); serve_until_play();
    pt(1'b0, 1'b1);
    chk("g1_p2_3", 32'(player2_score), 3);
    serve_until_play();
    for (int i = 0; i < 8; i++) begin
      pt(1'b1, 1'b0);
      chk("g1_p1_serve", 32'(state), 1);
      chk("g1_p1_dir", 32'(serve_dir), 1);
      chk("g1_p1_nowin", 32'(winner), 0);
      serve_until_play();
    end
    pt(1'b1, 1'b0);
    chk("g1_win_state", 32'(state), 3);
    chk("g1_win_p1", 32'(player1_score), 9);
    chk("g1_win_p2", 32'(player2_score), 3);
    chk("g1_winner", 32'(winner), 1);
    chk("g1_ball_en", 32'(ball_en), 0);
    pt(1'b1, 1'b0);
    pt(1'b0, 1'b1);
    chk("over_hold_p1", 32'(player1_score), 9);
    chk("over_hold_p2", 32'(player2_score), 3);
    chk("over_hold_state", 32'(state), 3);

    restart = 1'b1;
    step();
    chk("restart_state", 32'(state), 0);
    chk("restart_p1", 32'(player1_score), 9);
    chk("restart_p2", 32'(player2_score), 3);
    chk("restart_winner", 32'(winner), 1);
    for (int i = 0; i < 4; i++) step();
    restart = 1'b0;
    chk("restart_hold", 32'(state), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("g2_state", 32'(state), 1);
    chk("g2_p1", 32'(player1_score), 0);
    chk("g2_p2", 32'(player2_score), 0);
    chk("g2_winner", 32'(winner), 0);
    chk("g2_dir", 32'(serve_dir), 1);
    chk("g2_cd", 32'(countdown), 60);
    serve_until_play();

    // Game 2: margin rule
    for (int i = 0; i < 5; i++) begin
      pt(1'b1, 1'b0); serve_until_play();
      pt(1'b0, 1'b1); serve_until_play();
    end
    chk("g2_55_p1", 32'(player1_score), 5);
    chk("g2_55_p2", 32'(player2_score), 5);
    chk("g2_55_dir", 32'(serve_dir), 0);
    pt(1'b1, 1'b1);
    chk("simul_p1", 32'(player1_score), 6);
    chk("simul_p2", 32'(player2_score), 6);
    chk("simul_state", 32'(state), 1);
    chk("simul_dir", 32'(serve_dir), 0);
    chk("simul_cd", 32'(countdown), 60);
    serve_until_play();
    for (int i = 0; i < 3; i++) begin
      pt(1'b1, 1'b0);
      chk("g2_lead_serve", 32'(state), 1);
      serve_until_play();
      pt(1'b0, 1'b1); serve_until_play();
    end
    chk("g2_99_p1", 32'(player1_score), 9);
    chk("g2_99_p2", 32'(player2_score), 9);
    pt(1'b0, 1'b1);
    chk("m_910_state", 32'(state), 1);
    chk("m_910_p2", 32'(player2_score), 10);
    chk("m_910_winner", 32'(winner), 0);
    chk("m_910_dir", 32'(serve_dir), 0);
    serve_until_play();
    pt(1'b0, 1'b1);
    chk("m_911_state", 32'(state), 3);
    chk("m_911_p2", 32'(player2_score), 11);
    chk("m_911_winner", 32'(winner), 2);

    // Reset during serve
    restart = 1'b1; step(); restart = 1'b0;
    chk("r2_state", 32'(state), 0);
    start = 1'b1; step(); start = 1'b0;
    timing_tick = 1'b1;
    for (int i = 0; i < 43; i++) step();
    timing_tick = 1'b0;
    chk("mid_cd", 32'(countdown), 17);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_cd", 32'(countdown), 0);
    chk("mid_rst_dir", 32'(serve_dir), 1);
    chk("mid_rst_ball_en", 32'(ball_en), 0);
    chk("mid_rst_winner", 32'(winner), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pong_match_fsm.md
# pong_match_fsm

Parametrised match controller for the pong game: owns the game state machine, both score counters, the serve countdown and the optional pause mode. Sits in the logic layer between button inputs and the ball, pad and score paths. Generalises the fixed three-state menu/play/game-over controller with a configurable win score, a win-by-margin rule, a timed serve phase and a pause state.

## Interface

Parameters:
- `SCORE_W`, default 4: width of each score counter.
- `WIN_SCORE`, default 9: minimum score to win. Legal range 1 to 2^SCORE_W−1.
- `WIN_MARGIN`, default 1: required lead over the opponent to win. Must be ≥1.
- `SERVE_TICKS`, default 60: number of `timing_tick` pulses in the serve countdown. Must be ≥1.
- `CNT_W`, default 8: countdown width. Must satisfy 2^CNT_W > SERVE_TICKS.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `timing_tick`, input, 1: one-cycle frame tick.
- `start`, input, 1: level button, "up".
- `restart`, input, 1: level button, "down".
- `pause_btn`, input, 1: level button.
- `point_p1`, input, 1: one-cycle pulse; player 1 scored.
- `point_p2`, input, 1: one-cycle pulse; player 2 scored.
- `state`, output, 3: encoding MENU_START=0, SERVE=1, PLAY=2, GAME_OVER=3, PAUSE=4.
- `player1_score`, output, SCORE_W: player 1 score.
- `player2_score`, output, SCORE_W: player 2 score.
- `winner`, output, 2: 0 = none, 1 = player 1, 2 = player 2.
- `serve_dir`, output, 1: 0 = ball launched toward player 1, 1 = toward player 2.
- `ball_en`, output, 1: high only in PLAY.
- `countdown`, output, CNT_W: remaining serve ticks.

## Operation

- **Button edges:** `start`, `restart` and `pause_btn` are each registered once. Only a rising edge acts (current=1, previous=0). A held button never retriggers.
- **MENU_START:** a `start` edge clears both scores, clears `winner`, sets `serve_dir`=1, loads `countdown`=SERVE_TICKS, and moves to SERVE.
- **SERVE:** `countdown` decrements on each `timing_tick`.
  - A tick with `countdown`==1 moves to PLAY; `countdown` becomes 0.
  - `ball_en` is low throughout SERVE.
- **PLAY:** each point pulse increments its score, saturating at 2^SCORE_W−1.
  - Win condition: score ≥ WIN_SCORE and score ≥ opponent + WIN_MARGIN. Evaluate it on the post-increment scores.
  - Win: go to GAME_OVER and set `winner`.
  - No win: go to SERVE, reload `countdown`, and set `serve_dir` toward the player who conceded.
- **Simultaneous points:** both scores increment in the same cycle. WIN_MARGIN ≥1 prevents a double win. If neither side wins, go to SERVE with `serve_dir` unchanged.
- **Points outside PLAY** are ignored.
- **GAME_OVER:** scores and `winner` are held. A `restart` edge moves to MENU_START. Scores remain visible until the next `start`.
- **PAUSE:** see Configuration.
- **Priority when several events coincide in one cycle:** point > pause > everything else.
- **Unused encodings 5–7:** next state is MENU_START.

## Timing

- **Reset values:** `state`=MENU_START, scores=0, `winner`=0, `serve_dir`=1, `ball_en`=0, `countdown`=0, edge registers=0. Reset wins over every other input, including mid-countdown and mid-pause.
- **Button latency:** button rises at cycle N → new `state` visible at N+1.
- **Point latency:** pulse at cycle N → score and `state` both updated at N+1 (single registered step).
- **Countdown length:** SERVE lasts exactly SERVE_TICKS ticks. The tick that takes `countdown` from 1 to 0 switches `state` to PLAY on the next edge.
- **`ball_en`** is a registered decode, so it is exact with `state`.

## Configuration

- **Macro `PONG_PAUSE_EN` defined:**
  - A `pause_btn` edge in SERVE or PLAY saves the current state and enters PAUSE.
  - In PAUSE, `countdown` is frozen, points are ignored and `ball_en`=0.
  - A further `pause_btn` edge returns to the saved state with `countdown` unchanged.
  - A `restart` edge in PAUSE goes to MENU_START.
- **Macro undefined:** `pause_btn` is ignored, PAUSE is unreachable and the save register is not built. Encoding 4 is treated like any unused encoding.

## Test plan

- **Reset and start:** `rst` high for 2 cycles → all outputs at reset values. Pulse `start`, then 60 `timing_tick`s → PLAY exactly after the 60th tick; `ball_en`=1.
- **Normal win (WIN_SCORE=9, MARGIN=1):** 9 `point_p1` pulses, player 2 at 3 → GAME_OVER on the cycle after the 9th pulse; `winner`=1. Further pulses leave scores at 9:3.
- **Win by margin (MARGIN=2):** reach 9:9, then `point_p2` → SERVE at 9:10. Then `point_p2` → GAME_OVER at 9:11, `winner`=2. Also apply simultaneous p1/p2 pulses at 5:5 → 6:6, SERVE, `serve_dir` unchanged.
- **Edge detection and serve direction:** hold `start` 100 cycles → exactly one transition. `point_p2` at 0:0 → `serve_dir`=0, `countdown`=SERVE_TICKS.
- **Pause (PONG_PAUSE_EN):** pause at `countdown`=30 during SERVE; 10 ticks pass; unpause → `countdown` still 30. A `point_p1` pulse during PAUSE is ignored.
- **Reset mid-serve and restart:** `rst` during SERVE with `countdown`=17 → MENU_START, `countdown`=0. From GAME_OVER, `restart` edge → MENU_START with scores held; `start` edge → scores 0:0.
